riscv_dmem_responder: RTL
=========================

// Module: riscv_dmem_responder
// PURPOSE
//  Synthesizable data-memory responder for the riscv_final core's data port (dAddress/dWriteData/MemRead/MemWrite -> dReadData).
//  Serves a word RAM plus a small MMIO window (tohost/exit, cycle counter, fault counter) with 1-cycle synchronous read.
//  Replaces behavioural bench memories for FPGA runs; flags illegal accesses instead of returning X.
// PARAMETERS
//  DATA_MEMORY_START_ADDRESS  32'h00002000  byte base of RAM region
//  DATA_MEMORY_WORDS          2048          RAM depth in 32-bit words (power of 2)
//  MMIO_BASE                  32'h00007F00  byte base of 3-word MMIO window
//  INIT_FILE                  ""            $readmemh image for RAM; empty = no init
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous, active-low reset
//  dAddress     in   32  byte address from core
//  dWriteData   in   32  store data
//  MemRead      in   1   load request this cycle
//  MemWrite     in   1   store request this cycle
//  dReadData    out  32  load data, valid the cycle after MemRead
//  done         out  1   program halted via TOHOST write (sticky)
//  exit_code    out  32  value written to TOHOST
//  fault        out  1   sticky: any illegal access since reset
//  fault_addr   out  32  dAddress of first illegal access
//  fault_count  out  16  number of illegal accesses, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset (rst_n=0, async): dReadData=0, done=0, exit_code=0, fault=0, fault_addr=0, fault_count=0, cycle=0, state=RUN.
//   RAM contents not reset. A write coincident with reset assertion is not performed.
//  Decode (word-aligned only): RAM = [START, START+WORDS*4); TOHOST=MMIO_BASE+0; CYCLE=+4; FCOUNT=+8.
//   Anything else, or dAddress[1:0]!=0, is illegal.
//  State machine: RUN -> HALTED on legal TOHOST write; HALTED exits only by reset.
//  RUN, MemRead=1 (sampled at posedge): dReadData <= RAM word / exit_code / cycle / {16'b0,fault_count};
//   illegal -> dReadData <= 32'hDEADBEEF and fault event. Latency exactly 1 cycle.
//  MemRead=0: dReadData holds its last value.
//  RUN, MemWrite=1, MemRead=0: RAM word <= dWriteData; TOHOST: exit_code<=dWriteData, done<=1, ->HALTED;
//   CYCLE write ignored (legal); FCOUNT write clears fault_count (fault, fault_addr unchanged);
//   illegal -> no write, fault event.
//  MemRead=1 and MemWrite=1 together: read performed, write dropped, fault event (addr = dAddress).
//  Fault event: fault<=1; fault_addr<=dAddress only if fault was 0; fault_count+1 unless 16'hFFFF.
//   FCOUNT-clear and fault event in one cycle cannot occur (clear requires legal lone write).
//  cycle: 32-bit, +1 every clock in RUN, wraps FFFFFFFF->0, frozen in HALTED.
//  HALTED: reads still serviced (same as RUN); all writes ignored, not counted as faults; fault logic otherwise active.
//  RAM: single-port, inferred block RAM, write-first irrelevant (no same-cycle read+write).
// TESTING
//  Reset, write 0x12345678 to 0x2000, read 0x2000 -> dReadData=0x12345678 one cycle after MemRead, held while MemRead=0.
//  Read 0x1FFC and 0x2000+WORDS*4 -> dReadData=0xDEADBEEF, fault=1, fault_addr=0x1FFC, fault_count=2.
//  Read 0x2002 (unaligned) and MemRead+MemWrite on 0x2004 -> both fault, RAM[1] unchanged; write FCOUNT -> fault_count=0, fault still 1.
//  Run 100 clocks, read CYCLE -> value within 100..102; write 7 to TOHOST -> done=1, exit_code=7, cycle frozen on re-read.
//  After HALTED, write 0xAAAA to 0x2000 -> RAM unchanged, fault_count unchanged; deassert rst_n mid-read -> dReadData=0 immediately.
//  Force fault_count to saturate (65535+ illegal reads) -> stays 0xFFFF.

Source files
------------

// File: rtl/riscv_dmem_responder_if.sv
// Data-port bundle between the riscv_final core and its data memory.
// Status outputs ride along so FPGA wrappers see one bundle.
interface riscv_dmem_responder_if;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dReadData;
  logic        done;
  logic [31:0] exit_code;
  logic        fault;
  logic [31:0] fault_addr;
  logic [15:0] fault_count;

  modport master (
    output dAddress, dWriteData, MemRead, MemWrite,
    input  dReadData, done, exit_code,
    input  fault, fault_addr, fault_count
  );

  modport slave (
    input  dAddress, dWriteData, MemRead, MemWrite,
    output dReadData, done, exit_code,
    output fault, fault_addr, fault_count
  );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Word RAM plus tohost/cycle/fault-count MMIO for the core's data port.
// One-cycle synchronous reads; illegal accesses are flagged, not X'd.
module riscv_dmem_responder #(
  parameter logic [31:0] DATA_MEMORY_START_ADDRESS = 32'h0000_2000,
  parameter int          DATA_MEMORY_WORDS         = 2048,
  parameter logic [31:0] MMIO_BASE                 = 32'h0000_7F00,
  parameter string       INIT_FILE                 = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DATA_MEMORY_WORDS);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state;
  logic [31:0] cycle;
  logic [31:0] mmio_q;
  logic [31:0] ram_q;
  logic        src_ram;
  logic [31:0] mem [DATA_MEMORY_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          ram_hit;
  logic          is_toh;
  logic          is_cyc;
  logic          is_fc;
  logic          legal;
  logic          rd;
  logic          wr;
  logic          running;
  logic          lone_wr;
  logic          fault_ev;
  logic          ram_we;
  logic          ram_re;

  // RAM base is word aligned, so the low offset bits carry alignment
  assign off     = bus.dAddress - DATA_MEMORY_START_ADDRESS;
  assign idx     = off[AW+1:2];
  assign ram_hit = (off[31:AW+2] == '0) && (off[1:0] == 2'b00);
  assign is_toh  = bus.dAddress == MMIO_BASE;
  assign is_cyc  = bus.dAddress == MMIO_BASE + 32'd4;
  assign is_fc   = bus.dAddress == MMIO_BASE + 32'd8;
  assign legal   = ram_hit | is_toh | is_cyc | is_fc;

  assign rd      = bus.MemRead;
  assign wr      = bus.MemWrite;
  assign running = state == RUN;
  assign lone_wr = wr & ~rd & running;

  assign fault_ev = (rd & ~legal)
                  | (rd & wr & running)
                  | (lone_wr & ~legal);

  assign ram_we = lone_wr & ram_hit & rst_n;
  assign ram_re = rd & ram_hit;

  always_ff @(posedge clk) begin
    if (ram_we) mem[idx] <= bus.dWriteData;
    if (ram_re) ram_q <= mem[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      cycle           <= '0;
      mmio_q          <= '0;
      src_ram         <= 1'b0;
      bus.done        <= 1'b0;
      bus.exit_code   <= '0;
      bus.fault       <= 1'b0;
      bus.fault_addr  <= '0;
      bus.fault_count <= '0;
    end else begin
      if (running) cycle <= cycle + 32'd1;

      if (rd) begin
        src_ram <= ram_hit;
        if (!ram_hit) begin
          unique case (1'b1)
            is_toh:  mmio_q <= bus.exit_code;
            is_cyc:  mmio_q <= cycle;
            is_fc:   mmio_q <= {16'b0, bus.fault_count};
            default: mmio_q <= 32'hDEAD_BEEF;
          endcase
        end
      end

      if (lone_wr && is_toh) begin
        bus.exit_code <= bus.dWriteData;
        bus.done      <= 1'b1;
        state         <= HALTED;
      end

      if (fault_ev) begin
        bus.fault <= 1'b1;
        if (!bus.fault) bus.fault_addr <= bus.dAddress;
        if (bus.fault_count != 16'hFFFF)
          bus.fault_count <= bus.fault_count + 16'd1;
      end else if (lone_wr && is_fc) begin
        bus.fault_count <= '0;
      end
    end
  end

  assign bus.dReadData = src_ram ? ram_q : mmio_q;

endmodule
